// File: rtl/multi_input_debounce.sv
// Per-bit debouncer: each raw input is synchronized, then qualified over a number of
// slow sampling ticks before its clean level and a one-cycle press/release pulse change.
module multi_input_debounce #(
  parameter int par_inputs       = 4,
  parameter int par_stable_ticks = 20
) (
  input  logic                  i_clk_mhz,
  input  logic                  i_rst_mhz,
  input  logic                  i_ce_div,
  input  logic [par_inputs-1:0] ei_inputs,
  output logic [par_inputs-1:0] o_inputs_deb,
  output logic [par_inputs-1:0] o_inputs_press,
  output logic [par_inputs-1:0] o_inputs_release
);

  localparam int              CntW    = $clog2(par_stable_ticks + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(par_stable_ticks - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    ST_STABLE_LOW,
    ST_WAIT_HIGH,
    ST_STABLE_HIGH,
    ST_WAIT_LOW
  } state_t;

  logic [par_inputs-1:0] sync_meta_q;
  logic [par_inputs-1:0] s_sync_q;

  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz) begin
    if (!i_rst_mhz) begin
      sync_meta_q <= '0;
      s_sync_q    <= '0;
    end else begin
      sync_meta_q <= ei_inputs;
      s_sync_q    <= sync_meta_q;
    end
  end

  for (genvar g = 0; g < par_inputs; g++) begin : g_bit
    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            deb_q, deb_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;

    always_ff @(posedge i_clk_mhz or negedge i_rst_mhz) begin
      if (!i_rst_mhz) begin
        state_q <= ST_STABLE_LOW;
        cnt_q   <= '0;
        deb_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        deb_q   <= deb_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // A return to the stable level on any clock aborts qualification, tick or not.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        ST_STABLE_LOW: begin
          cnt_d = '0;
          deb_d = 1'b0;
          if (s_sync_q[g]) begin
            state_d = ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (!s_sync_q[g]) begin
            state_d = ST_STABLE_LOW;
            cnt_d   = '0;
          end else if (i_ce_div) begin
            if (cnt_q == CntLast) begin
              state_d = ST_STABLE_HIGH;
              deb_d   = 1'b1;
              press_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end
        end
        ST_STABLE_HIGH: begin
          cnt_d = '0;
          deb_d = 1'b1;
          if (!s_sync_q[g]) begin
            state_d = ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (s_sync_q[g]) begin
            state_d = ST_STABLE_HIGH;
            cnt_d   = '0;
          end else if (i_ce_div) begin
            if (cnt_q == CntLast) begin
              state_d = ST_STABLE_LOW;
              deb_d   = 1'b0;
              rel_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end
        end
        default: begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
          deb_d   = 1'b0;
        end
      endcase
    end

    assign o_inputs_deb[g]     = deb_q;
    assign o_inputs_press[g]   = press_q;
    assign o_inputs_release[g] = rel_q;
  end

endmodule

// File: tb/tb_multi_input_debounce.sv
// Directed bench for multi_input_debounce with 4 inputs, 3 stable ticks and a tick every 4 clocks.
// Inputs set right after an edge whose cycle count is a multiple of 4 are accepted 13 edges later.
module tb_multi_input_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [3:0] ei;
  logic [3:0] deb;
  logic [3:0] press;
  logic [3:0] rel;

  int cyc     = 0;
  int asserts = 0;
  int errors  = 0;

  multi_input_debounce #(
    .par_inputs      (4),
    .par_stable_ticks(3)
  ) dut (
    .i_clk_mhz       (clk),
    .i_rst_mhz       (rst_n),
    .i_ce_div        (ce),
    .ei_inputs       (ei),
    .o_inputs_deb    (deb),
    .o_inputs_press  (press),
    .o_inputs_release(rel)
  );

  always #5 clk = ~clk;

  // Advance one clock; the tick is high for every edge whose new count is 1 mod 4.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ce = (cyc % 4 == 0);
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  task automatic applyStimulus(input logic [3:0] val);
    ei = val;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expDeb,
                             input logic [3:0] expPress, input logic [3:0] expRel);
    asserts++;
    assert (deb === expDeb) else begin
      errors++;
      $error("[TB] FAIL %s deb observed=%b expected=%b", tag, deb, expDeb);
    end
    asserts++;
    assert (press === expPress) else begin
      errors++;
      $error("[TB] FAIL %s press observed=%b expected=%b", tag, press, expPress);
    end
    asserts++;
    assert (rel === expRel) else begin
      errors++;
      $error("[TB] FAIL %s release observed=%b expected=%b", tag, rel, expRel);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    ce    = 1'b0;
    ei    = 4'hF;
    #2 rst_n = 1'b0;
    stepN(3);
    checkOutput("reset_state", 4'h0, 4'h0, 4'h0);

    // Inputs held high through reset are accepted 3 ticks after release.
    align();
    rst_n = 1'b1;
    stepN(12);
    checkOutput("held_through_reset_pre", 4'h0, 4'h0, 4'h0);
    step();
    checkOutput("held_through_reset_press", 4'hF, 4'hF, 4'h0);
    step();
    checkOutput("held_through_reset_after", 4'hF, 4'h0, 4'h0);

    // Asynchronous reset between edges clears outputs at once.
    stepN(2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_immediate", 4'h0, 4'h0, 4'h0);
    stepN(2);
    checkOutput("async_reset_held", 4'h0, 4'h0, 4'h0);
    align();
    rst_n = 1'b1;
    stepN(12);
    checkOutput("rerelease_pre", 4'h0, 4'h0, 4'h0);
    step();
    checkOutput("rerelease_press", 4'hF, 4'hF, 4'h0);
    step();
    checkOutput("rerelease_after", 4'hF, 4'h0, 4'h0);

    // Release all four together.
    align();
    applyStimulus(4'h0);
    stepN(12);
    checkOutput("all_release_pre", 4'hF, 4'h0, 4'h0);
    step();
    checkOutput("all_release", 4'h0, 4'h0, 4'hF);
    step();
    checkOutput("all_release_after", 4'h0, 4'h0, 4'h0);

    // Clean press on bit 0.
    align();
    applyStimulus(4'b0001);
    stepN(12);
    checkOutput("clean_press_pre", 4'h0, 4'h0, 4'h0);
    step();
    checkOutput("clean_press", 4'b0001, 4'b0001, 4'h0);
    step();
    checkOutput("clean_press_after", 4'b0001, 4'h0, 4'h0);

    // Bit 1 high 9 clocks, low 1 clock, then high: the count restarts after the dip.
    align();
    applyStimulus(4'b0011);
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 9) applyStimulus(4'b0001);
      if (k == 10) applyStimulus(4'b0011);
      checkOutput("bounce_no_press", 4'b0001, 4'h0, 4'h0);
    end
    step();
    checkOutput("bounce_press", 4'b0011, 4'b0010, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("bounce_single_pulse", 4'b0011, 4'h0, 4'h0);
    end

    // Press then release on bit 2.
    align();
    applyStimulus(4'b0111);
    stepN(13);
    checkOutput("bit2_press", 4'b0111, 4'b0100, 4'h0);
    step();
    align();
    applyStimulus(4'b0011);
    stepN(12);
    checkOutput("bit2_release_pre", 4'b0111, 4'h0, 4'h0);
    step();
    checkOutput("bit2_release", 4'b0011, 4'h0, 4'b0100);
    step();
    checkOutput("bit2_release_after", 4'b0011, 4'h0, 4'h0);

    // Clear everything, then raise bits 0 and 3 together while bit 1 bounces.
    align();
    applyStimulus(4'h0);
    stepN(16);
    checkOutput("idle_before_simul", 4'h0, 4'h0, 4'h0);
    align();
    applyStimulus(4'b1011);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k >= 12) ei[1] = 1'b0;
      else if (k % 2 == 0) ei[1] = ~ei[1];
      checkOutput("simul_pre", 4'h0, 4'h0, 4'h0);
    end
    step();
    checkOutput("simul_press", 4'b1001, 4'b1001, 4'h0);
    step();
    checkOutput("simul_after", 4'b1001, 4'h0, 4'h0);

    // Reset after two ticks of qualification must discard the count.
    align();
    applyStimulus(4'h0);
    stepN(16);
    checkOutput("idle_before_midqual", 4'h0, 4'h0, 4'h0);
    align();
    applyStimulus(4'b0001);
    stepN(10);
    checkOutput("midqual_two_ticks", 4'h0, 4'h0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midqual_reset", 4'h0, 4'h0, 4'h0);
    stepN(2);
    align();
    rst_n = 1'b1;
    stepN(12);
    checkOutput("midqual_restart_pre", 4'h0, 4'h0, 4'h0);
    step();
    checkOutput("midqual_restart_press", 4'b0001, 4'b0001, 4'h0);
    step();
    checkOutput("midqual_restart_after", 4'b0001, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
